// File: rtl/alu_arbiter.sv
`default_nettype none
// alu_arbiter: round-robin sharing of one external combinational ALU between two
// valid/ready requesters; operands are held ALU_LAT cycles, then results are captured.
module alu_arbiter #(
    parameter int WIDTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_f,
    output logic             rsp_cout,
    output logic             rsp_v,
    output logic             busy,
    output logic [2:0]       alu_cntrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_f,
    input  logic             alu_cout,
    input  logic             alu_v
);

    localparam int            CW       = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_LAT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       cntrl_q, cntrl_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             cout_q, cout_d;
    logic             v_q, v_d;

    logic w_any;
    logic w_gnt;
    logic w_accept;

    // Contention goes to the requester not served last; a lone requester always wins.
    assign w_any      = req0_valid | req1_valid;
    assign w_gnt      = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    assign w_accept   = (state_q == S_IDLE) & w_any & ~rst;
    assign req0_ready = w_accept & ~w_gnt;
    assign req1_ready = w_accept & w_gnt;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        cntrl_d = cntrl_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        cout_d  = cout_q;
        v_d     = v_q;
        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    state_d = S_ISSUE;
                    last_d  = w_gnt;
                    cnt_d   = CNT_LOAD;
                    cntrl_d = w_gnt ? req1_op : req0_op;
                    a_d     = w_gnt ? req1_a  : req0_a;
                    b_d     = w_gnt ? req1_b  : req0_b;
                end
            end
            S_ISSUE: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    f_d     = alu_f;
                    cout_d  = alu_cout;
                    v_d     = alu_v;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                // Only the owner of the pending result can retire it.
                if (last_q ? rsp1_ready : rsp0_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            cntrl_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            cntrl_q <= cntrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
        end
    end

    assign rsp0_valid = (state_q == S_DONE) & ~last_q;
    assign rsp1_valid = (state_q == S_DONE) &  last_q;
    assign busy       = (state_q != S_IDLE);
    assign rsp_f      = f_q;
    assign rsp_cout   = cout_q;
    assign rsp_v      = v_q;
    assign alu_cntrl  = cntrl_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// Bench for alu_arbiter: directed cases plus random traffic scored against a
// transaction-level model of arbitration, latency and ALU results.
module tb_alu_arbiter;

    localparam int W    = 4;
    localparam int LAT  = 1;
    localparam int LAT3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [W-1:0] rsp_f;
    logic         rsp_cout, rsp_v, busy;
    logic [2:0]   alu_cntrl;
    logic [W-1:0] alu_a, alu_b, alu_f;
    logic         alu_cout, alu_v;

    logic         l3_req0_valid, l3_req0_ready, l3_req1_valid, l3_req1_ready;
    logic [2:0]   l3_req0_op, l3_req1_op;
    logic [W-1:0] l3_req0_a, l3_req0_b, l3_req1_a, l3_req1_b;
    logic         l3_rsp0_valid, l3_rsp0_ready, l3_rsp1_valid, l3_rsp1_ready;
    logic [W-1:0] l3_rsp_f;
    logic         l3_rsp_cout, l3_rsp_v, l3_busy;
    logic [2:0]   l3_alu_cntrl;
    logic [W-1:0] l3_alu_a, l3_alu_b, l3_alu_f;
    logic         l3_alu_cout, l3_alu_v;

    // External ALU: result {cout, v, f}; flags from add (even op) or sub (odd op).
    function automatic logic [W+1:0] alu_ref(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W:0]   s;
        logic [W-1:0] f;
        logic         v;
        if (op[0]) begin
            s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
            v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            s = {1'b0, a} + {1'b0, b};
            v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
        case (op)
            3'd0, 3'd1: f = s[W-1:0];
            3'd2:       f = a | b;
            3'd3:       f = a ^ b;
            3'd4:       f = a & b;
            3'd5:       f = ~(a & b);
            3'd6:       f = ~a;
            default:    f = b;
        endcase
        return {s[W], v, f};
    endfunction

    assign {alu_cout, alu_v, alu_f}          = alu_ref(alu_cntrl, alu_a, alu_b);
    assign {l3_alu_cout, l3_alu_v, l3_alu_f} = alu_ref(l3_alu_cntrl, l3_alu_a, l3_alu_b);

    alu_arbiter #(.WIDTH(W), .ALU_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_f(rsp_f), .rsp_cout(rsp_cout), .rsp_v(rsp_v), .busy(busy),
        .alu_cntrl(alu_cntrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_f(alu_f), .alu_cout(alu_cout), .alu_v(alu_v)
    );

    alu_arbiter #(.WIDTH(W), .ALU_LAT(LAT3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(l3_req0_valid), .req0_ready(l3_req0_ready), .req0_op(l3_req0_op),
        .req0_a(l3_req0_a), .req0_b(l3_req0_b),
        .req1_valid(l3_req1_valid), .req1_ready(l3_req1_ready), .req1_op(l3_req1_op),
        .req1_a(l3_req1_a), .req1_b(l3_req1_b),
        .rsp0_valid(l3_rsp0_valid), .rsp0_ready(l3_rsp0_ready),
        .rsp1_valid(l3_rsp1_valid), .rsp1_ready(l3_rsp1_ready),
        .rsp_f(l3_rsp_f), .rsp_cout(l3_rsp_cout), .rsp_v(l3_rsp_v), .busy(l3_busy),
        .alu_cntrl(l3_alu_cntrl), .alu_a(l3_alu_a), .alu_b(l3_alu_b),
        .alu_f(l3_alu_f), .alu_cout(l3_alu_cout), .alu_v(l3_alu_v)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Requester-side intent and the model's view of the one outstanding transaction.
    logic         m_vld [2];
    logic [2:0]   m_op  [2];
    logic [W-1:0] m_a   [2];
    logic [W-1:0] m_b   [2];
    logic         m_rdy [2];
    bit           m_busy;
    int           m_owner;
    int           m_age;
    logic         m_last;
    logic [W+1:0] m_res;
    logic [2:0]   m_xop;
    logic [W-1:0] m_xa, m_xb;
    int           d_acc [2];

    task automatic raise(input int r);
        m_vld[r] = 1'b1;
        m_op[r]  = 3'($urandom_range(0, 7));
        m_a[r]   = W'($urandom_range(0, 15));
        m_b[r]   = W'($urandom_range(0, 15));
    endtask

    // One clock cycle: drive intent, check outputs against the model, advance the model.
    task automatic step();
        int         g_exp;
        int         g_got;
        logic [1:0] v_exp;
        req0_valid = m_vld[0]; req0_op = m_op[0]; req0_a = m_a[0]; req0_b = m_b[0];
        req1_valid = m_vld[1]; req1_op = m_op[1]; req1_a = m_a[1]; req1_b = m_b[1];
        rsp0_ready = m_rdy[0]; rsp1_ready = m_rdy[1];
        #1;
        g_got = (req0_ready && req1_ready) ? 3 : (req1_ready ? 1 : (req0_ready ? 0 : 2));
        if (rst || m_busy || !(m_vld[0] || m_vld[1])) g_exp = 2;
        else if (m_vld[0] && m_vld[1])                g_exp = m_last ? 0 : 1;
        else                                          g_exp = m_vld[1] ? 1 : 0;
        chk("grant", g_got, g_exp);
        if (!rst && g_got < 2) d_acc[g_got]++;
        if (!rst) begin
            v_exp = 2'b00;
            if (m_busy && m_age >= LAT) v_exp[m_owner] = 1'b1;
            chk("rsp_valid", {rsp1_valid, rsp0_valid}, v_exp);
            chk("busy", busy, m_busy);
            if (m_busy) chk("alu_in", {alu_cntrl, alu_a, alu_b}, {m_xop, m_xa, m_xb});
            if (v_exp != 2'b00) chk("rsp_data", {rsp_cout, rsp_v, rsp_f}, m_res);
        end
        @(posedge clk);
        if (rst) begin
            m_busy = 1'b0;
            m_last = 1'b1;
        end else if (m_busy) begin
            if (m_age >= LAT && m_rdy[m_owner]) m_busy = 1'b0;
            else m_age++;
        end else if (g_exp != 2) begin
            m_busy   = 1'b1;
            m_owner  = g_exp;
            m_age    = 0;
            m_last   = g_exp[0];
            m_xop    = m_op[g_exp];
            m_xa     = m_a[g_exp];
            m_xb     = m_b[g_exp];
            m_res    = alu_ref(m_xop, m_xa, m_xb);
            m_vld[g_exp] = 1'b0;
        end
        #1;
    endtask

    task automatic set_req(input int r, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        m_vld[r] = 1'b1; m_op[r] = op; m_a[r] = a; m_b[r] = b;
    endtask

    initial begin
        rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            m_vld[r] = 1'b0; m_op[r] = '0; m_a[r] = '0; m_b[r] = '0;
            m_rdy[r] = 1'b0; d_acc[r] = 0;
        end
        m_busy = 1'b0; m_owner = 0; m_age = 0; m_last = 1'b1;
        m_res = '0; m_xop = '0; m_xa = '0; m_xb = '0;
        l3_req0_valid = 1'b0; l3_req0_op = '0; l3_req0_a = '0; l3_req0_b = '0;
        l3_req1_valid = 1'b0; l3_req1_op = '0; l3_req1_a = '0; l3_req1_b = '0;
        l3_rsp0_ready = 1'b0; l3_rsp1_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("reset_alu_cntrl", alu_cntrl, 3'd0);
        chk("reset_rsp", {rsp1_valid, rsp0_valid, rsp_cout, rsp_v, rsp_f}, 0);

        // Single add on requester 0.
        set_req(0, 3'b000, 4'h7, 4'h1);
        step(); step();
        chk("add_valid", {rsp1_valid, rsp0_valid}, 2'b01);
        chk("add_res", {rsp_cout, rsp_v, rsp_f}, {1'b0, 1'b1, 4'h8});
        m_rdy[0] = 1'b1; step(); m_rdy[0] = 1'b0;

        // Subtract on requester 1.
        set_req(1, 3'b001, 4'h3, 4'h5);
        step(); step();
        chk("sub_valid", {rsp1_valid, rsp0_valid}, 2'b10);
        chk("sub_res", {rsp_cout, rsp_v, rsp_f}, {1'b0, 1'b0, 4'hE});
        m_rdy[1] = 1'b1; step(); m_rdy[1] = 1'b0;

        // Backpressure on requester 0 while requester 1 waits.
        set_req(0, 3'b100, 4'hC, 4'hA);
        step();
        raise(1);
        step();
        chk("bp_res", {rsp_cout, rsp_v, rsp_f}, {1'b1, 1'b1, 4'h8});
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_req1_ready", req1_ready, 1'b0);
        end
        m_rdy[0] = 1'b1; step(); m_rdy[0] = 1'b0;
        chk("bp_next_grant", req1_ready, 1'b1);
        m_rdy[1] = 1'b1; step(); step(); m_rdy[1] = 1'b0;

        // Reset while a response is pending in DONE.
        raise(0);
        step(); step();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_done_rsp", {rsp1_valid, rsp0_valid}, 2'b00);
        chk("rst_done_busy", busy, 1'b0);
        chk("rst_done_cntrl", alu_cntrl, 3'd0);

        // Continuous contention: req0 wins first after reset, then strict alternation.
        m_vld[0] = 1'b0;
        d_acc[0] = 0; d_acc[1] = 0;
        m_rdy[0] = 1'b1; m_rdy[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            for (int r = 0; r < 2; r++) if (!m_vld[r]) raise(r);
            step();
        end
        chk("rr_acc0", d_acc[0], 2);
        chk("rr_acc1", d_acc[1], 2);
        for (int k = 0; k < 6; k++) step();

        // Random traffic with random response backpressure.
        for (int k = 0; k < 400; k++) begin
            for (int r = 0; r < 2; r++) begin
                if (!m_vld[r] && ($urandom_range(0, 1) == 1)) raise(r);
                m_rdy[r] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        m_rdy[0] = 1'b1; m_rdy[1] = 1'b1;
        for (int k = 0; k < 12; k++) step();
        chk("drain_idle", busy, 1'b0);

        // ALU_LAT=3: operands held three cycles, response after the third edge.
        l3_req0_op = 3'd2; l3_req0_a = 4'h5; l3_req0_b = 4'h9; l3_req0_valid = 1'b1;
        #1;
        chk("lat3_ready", l3_req0_ready, 1'b1);
        @(posedge clk); #1;
        l3_req0_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("lat3_hold", {l3_alu_cntrl, l3_alu_a, l3_alu_b}, {3'd2, 4'h5, 4'h9});
            chk("lat3_early", l3_rsp0_valid, 1'b0);
            @(posedge clk); #1;
        end
        chk("lat3_valid", l3_rsp0_valid, 1'b1);
        chk("lat3_res", {l3_rsp_cout, l3_rsp_v, l3_rsp_f}, {1'b0, 1'b0, 4'hD});
        l3_rsp0_ready = 1'b1;
        @(posedge clk); #1;
        l3_rsp0_ready = 1'b0;
        chk("lat3_idle", l3_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
